// File: rtl/sp_pkg.sv
// Shared definitions for the PS/SP serial link.
// Holds the comma byte used by both transmitter and receiver, the receiver
// state encoding, and the default number of aligned commas needed to lock.
package sp_pkg;

  localparam logic [7:0] COMMA_BYTE      = 8'hBC;
  localparam int         DEF_SYNC_COMMAS = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } sp_state_t;

endpackage

// File: rtl/sp_receiver.sv
// Serial-to-parallel receiver for the PS/SP link.
// Finds byte alignment from comma bytes, then emits one data byte per
// 8 clocks with a single-cycle valid pulse. Commas are never emitted.
//
// Ports:
//   clk_SP        in   receiver bit clock, rising edge
//   reset_L       in   asynchronous active-low reset
//   data_in_SP    in   serial data, MSB first
//   data_out_SP   out  [7:0] last received non-comma byte (held)
//   valid_out_SP  out  one-cycle pulse when data_out_SP updates
//   active_SP     out  high while aligned and locked
//
// state  | meaning
// SEARCH | sliding compare of sr against the comma every cycle
// SYNC   | aligned to a candidate comma, counting commas at byte boundaries
// ACTIVE | locked; non-comma bytes at boundaries are output (exit by reset)
module sp_receiver
  import sp_pkg::*;
#(
  parameter int SYNC_COMMAS = DEF_SYNC_COMMAS
) (
  input  logic       clk_SP,
  input  logic       reset_L,
  input  logic       data_in_SP,
  output logic [7:0] data_out_SP,
  output logic       valid_out_SP,
  output logic       active_SP
);

  localparam logic [3:0] SYNC_N = 4'(SYNC_COMMAS);

  sp_state_t  state, state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] comma_cnt, comma_cnt_nxt;
  logic [3:0] comma_inc;
  logic       valid_nxt;
  logic       load_data;
  logic       is_comma;
  logic       boundary;

  assign is_comma  = (sr == COMMA_BYTE);
  assign boundary  = (state != SEARCH) && (bit_cnt == 3'd0);
  assign comma_inc = comma_cnt + 4'd1;
  assign active_SP = (state == ACTIVE);

  always_ff @(posedge clk_SP or negedge reset_L) begin
    if (!reset_L) state <= SEARCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    comma_cnt_nxt = comma_cnt;
    valid_nxt     = 1'b0;
    load_data     = 1'b0;
    case (state)
      SEARCH: begin
        if (is_comma) begin
          // The detecting cycle counts as bit 0 of the next byte, hence 1.
          bit_cnt_nxt   = 3'd1;
          comma_cnt_nxt = 4'd1;
          state_nxt     = (SYNC_COMMAS == 1) ? ACTIVE : SYNC;
        end
      end
      SYNC: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_nxt = comma_inc;
            if (comma_inc == SYNC_N) state_nxt = ACTIVE;
          end else begin
            // sr keeps shifting, so SEARCH resumes next cycle without losing bits.
            comma_cnt_nxt = 4'd0;
            state_nxt     = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary && !is_comma) begin
          load_data = 1'b1;
          valid_nxt = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_SP or negedge reset_L) begin
    if (!reset_L) begin
      sr           <= 8'h00;
      bit_cnt      <= 3'd0;
      comma_cnt    <= 4'd0;
      data_out_SP  <= 8'h00;
      valid_out_SP <= 1'b0;
    end else begin
      sr           <= {sr[6:0], data_in_SP};
      bit_cnt      <= bit_cnt_nxt;
      comma_cnt    <= comma_cnt_nxt;
      valid_out_SP <= valid_nxt;
      if (load_data) data_out_SP <= sr;
    end
  end

endmodule

// File: tb/tb_sp_receiver.sv
// Directed bench for sp_receiver: one instance with the default lock depth
// and one with SYNC_COMMAS = 1, both fed the same serial stream.
module tb_sp_receiver;

  logic       clk_SP = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in_SP = 1'b0;
  logic [7:0] data_out0, data_out1;
  logic       valid0, valid1, active0, active1;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  logic [7:0] vq0[$];
  int         ve0[$];
  logic [7:0] vq1[$];
  int         ve1[$];
  int         act0_edge;
  int         act1_edge;
  int         t0;
  int         tl[4];

  always #5 clk_SP = ~clk_SP;

  sp_receiver dut0 (
    .clk_SP      (clk_SP),
    .reset_L     (reset_L),
    .data_in_SP  (data_in_SP),
    .data_out_SP (data_out0),
    .valid_out_SP(valid0),
    .active_SP   (active0)
  );

  sp_receiver #(.SYNC_COMMAS(1)) dut1 (
    .clk_SP      (clk_SP),
    .reset_L     (reset_L),
    .data_in_SP  (data_in_SP),
    .data_out_SP (data_out1),
    .valid_out_SP(valid1),
    .active_SP   (active1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    vq0.delete(); ve0.delete(); vq1.delete(); ve1.delete();
    act0_edge = -1;
    act1_edge = -1;
  endtask

  // Drive one bit between edges, then observe both instances just after the edge.
  task automatic bit_tx(input logic b);
    data_in_SP = b;
    @(posedge clk_SP);
    #1;
    edge_n++;
    if (valid0) begin vq0.push_back(data_out0); ve0.push_back(edge_n); end
    if (valid1) begin vq1.push_back(data_out1); ve1.push_back(edge_n); end
    if (active0 && act0_edge < 0) act0_edge = edge_n;
    if (active1 && act1_edge < 0) act1_edge = edge_n;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_tx(v[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) bit_tx(1'b0);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    send_zeros(2);
    reset_L = 1'b1;
  endtask

  initial begin
    logic [7:0] b12;
    b12 = 8'h12;

    // Reset state
    clear_mon();
    #2;
    chk_eq("rst_data", data_out0, 8'h00);
    chk_eq("rst_valid", valid0, 1'b0);
    chk_eq("rst_active", active0, 1'b0);
    do_reset();

    // Idle stream at random bit phase
    send_zeros(8 + $urandom_range(0, 7));
    clear_mon();
    send_byte(8'hBC);
    t0 = edge_n;
    for (int i = 0; i < 5; i++) send_byte(8'hBC);
    chk_eq("lock_edge", act0_edge, t0 + 25);
    chk_eq("idle_no_valid", vq0.size(), 0);

    // Back-to-back data
    clear_mon();
    send_byte(8'hA5); tl[0] = edge_n;
    send_byte(8'h3C); tl[1] = edge_n;
    send_byte(8'hFF); tl[2] = edge_n;
    send_byte(8'h00); tl[3] = edge_n;
    send_byte(8'hBC);
    chk_eq("b2b_count", vq0.size(), 4);
    chk_eq("b2b_d0", vq0[0], 8'hA5);
    chk_eq("b2b_d1", vq0[1], 8'h3C);
    chk_eq("b2b_d2", vq0[2], 8'hFF);
    chk_eq("b2b_d3", vq0[3], 8'h00);
    chk_eq("b2b_e0", ve0[0], tl[0] + 1);
    chk_eq("b2b_e1", ve0[1], tl[1] + 1);
    chk_eq("b2b_e2", ve0[2], tl[2] + 1);
    chk_eq("b2b_e3", ve0[3], tl[3] + 1);

    // Commas interleaved with data
    clear_mon();
    send_byte(8'hBC);
    send_byte(8'h5A);
    send_byte(8'hBC);
    bit_tx(b12[7]);
    chk_eq("hold_5a", data_out0, 8'h5A);
    for (int i = 6; i >= 0; i--) bit_tx(b12[i]);
    send_byte(8'hBC);
    chk_eq("mix_count", vq0.size(), 2);
    chk_eq("mix_d0", vq0[0], 8'h5A);
    chk_eq("mix_d1", vq0[1], 8'h12);

    // SYNC interrupted by a non-comma
    do_reset();
    send_zeros(8);
    clear_mon();
    send_byte(8'hBC);
    t0 = edge_n;
    send_byte(8'hBC);
    send_byte(8'h77);
    for (int i = 0; i < 5; i++) send_byte(8'hBC);
    chk_eq("relock_edge", act0_edge, t0 + 49);
    chk_eq("sync_no_valid", vq0.size(), 0);

    // Reset mid-byte while ACTIVE
    send_byte(8'h5A);
    bit_tx(1'b1);
    chk_eq("pre_rst_valid", valid0, 1'b1);
    chk_eq("pre_rst_data", data_out0, 8'h5A);
    reset_L = 1'b0;
    #2;
    chk_eq("async_data", data_out0, 8'h00);
    chk_eq("async_valid", valid0, 1'b0);
    chk_eq("async_active", active0, 1'b0);
    @(posedge clk_SP);
    #1;
    edge_n++;
    reset_L = 1'b1;
    bit_tx(1'b0);
    chk_eq("post_rst_active", active0, 1'b0);
    send_zeros(8);
    clear_mon();
    send_byte(8'hBC);
    t0 = edge_n;
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    chk_eq("rst_relock_edge", act0_edge, t0 + 25);
    chk_eq("rst_relock_no_valid", vq0.size(), 0);

    // Single-comma lock
    do_reset();
    send_zeros(8);
    clear_mon();
    send_byte(8'hBC);
    t0 = edge_n;
    send_byte(8'hC3);
    send_byte(8'hBC);
    chk_eq("one_lock_edge", act1_edge, t0 + 1);
    chk_eq("one_count", vq1.size(), 1);
    chk_eq("one_data", vq1[0], 8'hC3);
    chk_eq("one_edge", ve1[0], t0 + 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_receiver.md
# sp_receiver

Serial-to-parallel receiver for the PS/SP link. It accepts the MSB-first bit stream from the parallel-to-serial transmitter, where the idle/comma byte is 8'hBC. It finds byte alignment from commas and, once locked, outputs one 8-bit data byte per 8 clocks with a valid flag. It sits at the far end of the serial lane and feeds the downstream byte FIFO/logic.

## Interface
- SYNC_COMMAS, 4: consecutive aligned 8'hBC bytes, including the first detected, needed to enter ACTIVE; legal range 1-15.
- COMMA, 8'hBC: idle/alignment byte.
- clk_SP  input  1  receiver clock, same rate as the transmitter's bit clock; all logic on the rising edge.
- reset_L  input  1  asynchronous, active-low reset; clears all state immediately.
- data_in_SP  input  1  serial data, MSB of each byte first.
- data_out_SP  output  8  last received non-comma byte; holds its value between updates.
- valid_out_SP  output  1  one-cycle pulse when data_out_SP is updated with a new byte.
- active_SP  output  1  high while in ACTIVE (aligned and locked).

## Operation
- Shift register sr[7:0] updates every cycle, including during SEARCH: sr <= {sr[6:0], data_in_SP}.
- bit_cnt[2:0] increments mod 8 every cycle while in SYNC or ACTIVE. A byte boundary is any cycle in SYNC or ACTIVE with bit_cnt == 0; at that cycle sr holds a complete byte.
- comma_cnt[3:0] counts aligned commas.
- States (registered, reset to SEARCH):
  - SEARCH: every cycle, compare sr against COMMA.
    - On match: bit_cnt <= 1, comma_cnt <= 1.
    - If SYNC_COMMAS == 1, go to ACTIVE; otherwise go to SYNC.
  - SYNC: at each boundary:
    - sr == COMMA: comma_cnt increments. When the new count equals SYNC_COMMAS, go to ACTIVE.
    - sr != COMMA: go to SEARCH, comma_cnt <= 0. The comparison resumes on the next cycle with no bit lost, because sr keeps shifting.
  - ACTIVE: at each boundary:
    - sr != COMMA: data_out_SP <= sr, valid_out_SP <= 1.
    - sr == COMMA: valid_out_SP <= 0 and data_out_SP holds.
    - ACTIVE is left only by reset. Misaligned data after lock is not detected.
- valid_out_SP is 0 on every non-boundary cycle and in SEARCH/SYNC.
- Reset values: data_out_SP = 8'h00, valid_out_SP = 0, active_SP = 0, sr = 0, bit_cnt = 0, comma_cnt = 0, state = SEARCH.
- Reset asserted mid-byte: all outputs clear asynchronously. After release, alignment restarts from SEARCH and no partial byte is ever emitted.
- The transmitter's reset output (constant 0) never matches COMMA, so the receiver stays in SEARCH until the transmitter sends idle.

## Timing
- Latency: the LSB of byte N is sampled at edge t. data_out_SP/valid_out_SP show byte N after edge t+1.
- Lock time:
  - The first comma is complete in sr after edge t0 and detected at edge t0+1.
  - SYNC boundaries then fall at edges t0+9, t0+17, ...
  - With SYNC_COMMAS = 4, active_SP rises after edge t0+25.
- Throughput in ACTIVE: at most one valid pulse per 8 cycles. Valid pulses are always exactly a multiple of 8 cycles apart.
- active_SP changes only on the state-register edge; it is a Moore output.

## Structure
- Shared package sp_pkg:
  - COMMA_BYTE = 8'hBC, shared with the transmitter.
  - State encoding localparams: SEARCH = 2'd0, SYNC = 2'd1, ACTIVE = 2'd2.
  - Default SYNC_COMMAS.
- Single module. The comma comparator is one equality compare and does not justify its own sub-module.

## Test plan
- Reset, then idle stream of 8'hBC, bit phase random in 0-7 -> active_SP rises 25 cycles after the first complete comma; valid_out_SP stays 0.
- Locked, then bytes 8'hA5, 8'h3C, 8'hFF, 8'h00 back-to-back -> four valid pulses 8 cycles apart; data_out_SP = A5, 3C, FF, 00, each one cycle after its LSB.
- Locked, stream BC, 5A, BC, 12 -> exactly two pulses, carrying 5A and 12; data_out_SP holds 5A through the following BC.
- SYNC interrupted: BC, BC, 8'h77, then continuous BC -> returns to SEARCH on 77, relocks after 4 fresh commas; no valid pulse from 77.
- reset_L asserted for 1 cycle mid-byte while ACTIVE -> outputs 0 immediately, active_SP = 0; relock from SEARCH after release.
- SYNC_COMMAS = 1, single BC followed by 8'hC3 -> ACTIVE after the first detection; C3 is output 8 cycles later.
